shift_div_datapath: RTL



---
 rtl/div_pkg.sv | 27 ++
 rtl/div_shift_step.sv | 36 +++
 rtl/shift_div_datapath.sv | 177 +++++++++++++++++
 3 files changed

// File: rtl/div_pkg.sv
// ---------------------------------------------------------------------------
// div_pkg : shared states and constants for the shift/add-subtract divider
// Revision 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package div_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2,
    DONE = 2'd3
  } state_e;

  localparam logic [2:0] MAX_SHIFT = 3'd4;

  localparam logic OP_SUB = 1'b1;
  localparam logic OP_ADD = 1'b0;

  function automatic logic [2:0] clamp_shift(input logic [2:0] shift);
    return (shift > MAX_SHIFT) ? MAX_SHIFT : shift;
  endfunction

endpackage

`default_nettype wire

// File: rtl/div_shift_step.sv
// ---------------------------------------------------------------------------
// div_shift_step : one combinational add/sub, shift and quotient-fill step
// Revision 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module div_shift_step
  import div_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] acc,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] qr,
  input  logic [2:0]       shift,
  input  logic             op,
  output logic [WIDTH-1:0] acc_next,
  output logic [WIDTH-1:0] qr_next,
  output logic [2:0]       shamt
);

  logic [WIDTH-1:0] sum;
  logic [WIDTH-1:0] fill;

  always_comb begin
    shamt    = clamp_shift(shift);
    sum      = (op == OP_SUB) ? (acc - b) : (acc + b);
    acc_next = sum << shamt;
    // Vacated quotient bits all take the value of the operation just done.
    fill     = {WIDTH{op}} & ~({WIDTH{1'b1}} << shamt);
    qr_next  = (qr << shamt) | fill;
  end

endmodule

`default_nettype wire

// File: rtl/shift_div_datapath.sv
// ---------------------------------------------------------------------------
// shift_div_datapath : operand datapath and start/done handshake for the
// variable-shift divider. Optional watchdog under STEP_LIMIT_EN.  Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module shift_div_datapath
  import div_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int CNT_INIT  = 7,
  parameter int MAX_STEPS = 15
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             start,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  input  logic [2:0]       shift,
  input  logic             op,
  input  logic             finish,
  output logic             ready,
  output logic             done,
  output logic [WIDTH-1:0] q_out,
  output logic [WIDTH-1:0] r_out,
  output logic [WIDTH-1:0] result,
  output logic [2:0]       counter,
  output logic             ctl_rstn,
  output logic             err
);

  localparam logic [2:0] CNT_INIT_V = 3'(CNT_INIT);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] qr_q, qr_d;
  logic [2:0]       cnt_q, cnt_d;
  logic             ctl_rstn_q, ctl_rstn_d;

  logic [WIDTH-1:0] step_acc;
  logic [WIDTH-1:0] step_qr;
  logic [2:0]       step_shamt;
  logic [2:0]       cnt_sat;
  logic             limit_hit;

  div_shift_step #(
    .WIDTH (WIDTH)
  ) u_step (
    .acc      (acc_q),
    .b        (b_q),
    .qr       (qr_q),
    .shift    (shift),
    .op       (op),
    .acc_next (step_acc),
    .qr_next  (step_qr),
    .shamt    (step_shamt)
  );

  assign cnt_sat = (cnt_q > step_shamt) ? (cnt_q - step_shamt) : 3'd0;

  always_comb begin
    state_d    = state_q;
    acc_d      = acc_q;
    b_d        = b_q;
    qr_d       = qr_q;
    cnt_d      = cnt_q;
    ctl_rstn_d = ctl_rstn_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          acc_d      = a_in;
          b_d        = b_in;
          qr_d       = '0;
          cnt_d      = CNT_INIT_V;
          ctl_rstn_d = 1'b0;
          state_d    = LOAD;
        end
      end
      LOAD: begin
        ctl_rstn_d = 1'b1;
        state_d    = RUN;
      end
      RUN: begin
        if (finish) begin
          state_d = DONE;
        end else begin
          acc_d = step_acc;
          qr_d  = step_qr;
          cnt_d = cnt_sat;
          if (limit_hit) begin
            state_d = DONE;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q    <= IDLE;
      acc_q      <= '0;
      b_q        <= '0;
      qr_q       <= '0;
      cnt_q      <= '0;
      ctl_rstn_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      acc_q      <= acc_d;
      b_q        <= b_d;
      qr_q       <= qr_d;
      cnt_q      <= cnt_d;
      ctl_rstn_q <= ctl_rstn_d;
    end
  end

`ifdef STEP_LIMIT_EN
  localparam int RUN_W = $clog2(MAX_STEPS + 1);
  localparam logic [RUN_W-1:0] RUN_LAST = RUN_W'(MAX_STEPS - 1);

  logic [RUN_W-1:0] run_cnt_q, run_cnt_d;
  logic             err_q, err_d;
  logic             accept;
  logic             step_fire;

  assign accept    = (state_q == IDLE) && start;
  assign step_fire = (state_q == RUN) && !finish;
  // The step that completes MAX_STEPS is still applied, then the run aborts.
  assign limit_hit = (run_cnt_q == RUN_LAST);

  always_comb begin
    run_cnt_d = run_cnt_q;
    err_d     = err_q;
    if (accept) begin
      run_cnt_d = '0;
      err_d     = 1'b0;
    end else if (step_fire) begin
      run_cnt_d = run_cnt_q + 1'b1;
      if (limit_hit) begin
        err_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      run_cnt_q <= '0;
      err_q     <= 1'b0;
    end else begin
      run_cnt_q <= run_cnt_d;
      err_q     <= err_d;
    end
  end

  assign err = err_q;
`else
  assign limit_hit = 1'b0;
  assign err       = 1'b0;
`endif

  assign ready    = (state_q == IDLE);
  assign done     = (state_q == DONE);
  assign result   = acc_q;
  assign r_out    = acc_q;
  assign q_out    = qr_q;
  assign counter  = cnt_q;
  assign ctl_rstn = ctl_rstn_q;

endmodule

`default_nettype wire
